sar_busca_comparador: RTL
=========================

// Module: sar_busca_comparador
// PURPOSE
// - Successive-approximation (binary-search) controller on the consumer side of the magnitude comparator.
// - Drives candidate value GUESS onto comparator input B while the hidden target sits on input A.
// - Reads the comparator's AltB/AeqB/AgtB flags once per cycle and narrows the search until equality.
// - Reports FOUND/DONE. Used by the guessing/lock datapath to recover an unknown WIDTH-bit code.
// PARAMETERS
// - WIDTH  5  bit width of target and GUESS; search range 0 .. 2**WIDTH-1
// PORTS
// - clk       in   1        single clock, all state updates on rising edge
// - reset     in   1        synchronous, active-high; overrides every other input
// - start     in   1        begin a search; honoured only in IDLE or DONE
// - AltB      in   1        comparator flag: target < GUESS
// - AeqB      in   1        comparator flag: target == GUESS
// - AgtB      in   1        comparator flag: target > GUESS
// - guess     out  WIDTH    candidate driven to comparator B (registered)
// - busy      out  1        high while in PROBE
// - done      out  1        high while in DONE (level, held until start or reset)
// - found     out  1        valid with done: 1 = guess equals target, 0 = search failed
// - err       out  1        valid with done: flags were not one-hot (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE, lo=0, hi=2**WIDTH-1, guess=0, busy=0, done=0, found=0, err=0.
// - Internal regs: lo, hi (WIDTH bits); mid = (lo+hi)>>1 computed on a WIDTH+1-bit sum (no overflow).
// - FSM: IDLE -> PROBE -> DONE -> (start) PROBE. Three states, no others.
// - IDLE/DONE + start: lo<=0, hi<=2**WIDTH-1, guess<=2**(WIDTH-1)-1, busy<=1, done/found/err<=0, go PROBE.
// - PROBE: comparator is external combinational logic; flags for current guess sampled every cycle:
//   - AeqB: found<=1, go DONE; guess held.
//   - AgtB: if guess==hi -> found<=0, go DONE; else lo<=guess+1, guess<=(guess+1+hi)>>1.
//   - AltB: if guess==lo -> found<=0, go DONE; else hi<=guess-1, guess<=(lo+guess-1)>>1.
// - One probe per cycle; latency start -> done <= WIDTH+1 probes (6 for WIDTH=5), plus entry cycle.
// - guess never leaves [lo,hi]; no wrap-around below 0 or above 2**WIDTH-1 (terminal checks above).
// - On entering DONE: busy<=0, done<=1; guess, found, err held stable until next start or reset.
// - start while in PROBE: ignored, search continues unaffected.
// - start and terminal event in same cycle: go DONE; start not re-sampled until DONE visible.
// - reset mid-search: back to IDLE next edge, all outputs to reset values, search abandoned.
// - Target assumed stable for the whole search; a target change mid-search gives undefined guess,
//   but the search still terminates within WIDTH+1 probes.
// CONFIGURATION
// - Macro SAR_FLAG_CHECK_EN:
//   - Defined: in PROBE, flags not exactly one-hot (none or >1 high) -> err<=1, found<=0, go DONE.
//   - Undefined: no check, err tied 0; priority AeqB > AgtB > AltB; all-zero flags hold state (retry).
// TESTING
// - target=19, start pulse -> guesses 15,23,19; done=1 found=1 guess=19 after 3 probes; busy low.
// - target=0 -> guesses 15,7,3,1,0; found=1 after 5 probes; target=31 -> 15,23,27,29,30,31, 6 probes.
// - Comparator model forced AltB=1 always -> guesses 15,7,3,1,0 then done=1 found=0 err=0.
// - SAR_FLAG_CHECK_EN set, flags forced 3'b000 at 2nd probe -> done=1 err=1 found=0; unset -> holds.
// - reset asserted during 2nd probe (target=19) -> next cycle IDLE, guess=0, busy=0, done=0.
// - start held high throughout search (target=9) -> single search, no restart; done then restart.

Source files
------------

// File: rtl/sar_busca_comparador.sv
// Binary-search controller driving an external magnitude comparator; one probe/cycle, <= WIDTH+1 probes.
// Latency: start -> first guess 1 cycle; no backpressure, start ignored while busy. Option: SAR_FLAG_CHECK_EN.
module sar_busca_comparador #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             AltB,
   input  logic             AeqB,
   input  logic             AgtB,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PROBE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [WIDTH-1:0] MAX_VAL   = '1;
   localparam logic [WIDTH-1:0] FIRST_VAL = {1'b0, {(WIDTH-1){1'b1}}};

   logic [1:0]       state;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;

   // Sums are one bit wider so lo+hi style midpoints never overflow.
   logic [WIDTH:0] up_sum;
   logic [WIDTH:0] dn_sum;

   assign up_sum = {1'b0, guess} + {{WIDTH{1'b0}}, 1'b1} + {1'b0, hi};
   assign dn_sum = {1'b0, lo} + {1'b0, guess} - {{WIDTH{1'b0}}, 1'b1};

   logic flags_bad;
`ifdef SAR_FLAG_CHECK_EN
   assign flags_bad = ({AltB, AeqB, AgtB} != 3'b001) &&
                      ({AltB, AeqB, AgtB} != 3'b010) &&
                      ({AltB, AeqB, AgtB} != 3'b100);
`else
   assign flags_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         lo    <= '0;
         hi    <= MAX_VAL;
         guess <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         found <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state <= ST_PROBE;
                  lo    <= '0;
                  hi    <= MAX_VAL;
                  guess <= FIRST_VAL;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  found <= 1'b0;
                  err   <= 1'b0;
               end
            end
            ST_PROBE: begin
               if (flags_bad) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  found <= 1'b0;
                  err   <= 1'b1;
               end else if (AeqB) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  found <= 1'b1;
               end else if (AgtB) begin
                  if (guess == hi) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     found <= 1'b0;
                  end else begin
                     lo    <= guess + 1'b1;
                     guess <= up_sum[WIDTH:1];
                  end
               end else if (AltB) begin
                  if (guess == lo) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     found <= 1'b0;
                  end else begin
                     hi    <= guess - 1'b1;
                     guess <= dn_sum[WIDTH:1];
                  end
               end
               // No flag raised: hold everything and retry next cycle.
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
